// File: rtl/tpu_seq_pkg.sv
// Shared types and widths for the TPU operation sequencer.
package tpu_seq_pkg;

  localparam int unsigned OPERAND_W = 8;
  localparam int unsigned RESULT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    READ,
    CAPTURE,
    RESP
  } state_t;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/tpu_op_sequencer_if.sv
// Host-side request/response handshake of the TPU operation sequencer.
interface tpu_op_sequencer_if;
  import tpu_seq_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [OPERAND_W-1:0] req_a;
  logic [OPERAND_W-1:0] req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [RESULT_W-1:0]  resp_data;
  logic                 resp_err;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/tpu_seq_fifo.sv
// Operand-pair FIFO with registered full/empty/count flags.
module tpu_seq_fifo
  import tpu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  operand_pair_t              wdata,
  output operand_pair_t              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  operand_pair_t    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign rdata     = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tpu_op_sequencer.sv
// Sequences one TPU engine job at a time from a buffered operand FIFO.
// Optional WAIT watchdog enabled by defining TPU_SEQ_TIMEOUT_EN.
module tpu_op_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  tpu_op_sequencer_if.slave    host,
  output logic                 eng_sync,
  output logic                 eng_out_hl,
  output logic [OPERAND_W-1:0] eng_in1,
  output logic [OPERAND_W-1:0] eng_in2,
  input  logic                 eng_ready,
  input  logic                 eng_error,
  input  logic [RESULT_W-1:0]  eng_out,
  output logic                 busy,
  output logic [7:0]           err_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t           state, next_state;
  operand_pair_t    fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  logic             tmo_hit;
  logic             sync_d, hl_d, resp_valid_d, busy_d, load_err, err_accept;

  assign host.req_ready = !fifo_full;
  assign fifo_push      = host.req_valid && !fifo_full;
  assign fifo_pop       = (state == IDLE) && !fifo_empty;
  assign fifo_wdata     = {host.req_a, host.req_b};
  assign err_accept     = (state == RESP) && host.resp_ready && host.resp_err;

  tpu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef TPU_SEQ_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Cleared while issuing so it starts at zero on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (!reset)                tmo_cnt <= '0;
    else if (state == ISSUE)   tmo_cnt <= '0;
    else if (state == WAIT)    tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign tmo_hit = (state == WAIT) && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT: begin
        if (eng_error)      next_state = RESP;
        else if (eng_ready) next_state = READ;
        else if (tmo_hit)   next_state = RESP;
      end
      READ:    next_state = CAPTURE;
      CAPTURE: next_state = RESP;
      RESP:    if (host.resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Decode of the upcoming state; registered below so pulses align with it.
  always_comb begin
    sync_d       = (next_state == ISSUE);
    hl_d         = (next_state == READ);
    resp_valid_d = (next_state == RESP);
    busy_d       = (next_state != IDLE) || fifo_push || (fifo_count != '0);
    load_err     = (state == WAIT) && (next_state == RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      eng_sync        <= 1'b0;
      eng_out_hl      <= 1'b0;
      eng_in1         <= '0;
      eng_in2         <= '0;
      host.resp_valid <= 1'b0;
      host.resp_data  <= '0;
      host.resp_err   <= 1'b0;
      busy            <= 1'b0;
      err_count       <= '0;
    end else begin
      eng_sync        <= sync_d;
      eng_out_hl      <= hl_d;
      host.resp_valid <= resp_valid_d;
      busy            <= busy_d;
      if (fifo_pop) begin
        eng_in1 <= fifo_rdata.a;
        eng_in2 <= fifo_rdata.b;
      end
      if (load_err) begin
        host.resp_data <= '0;
        host.resp_err  <= 1'b1;
      end else if (state == CAPTURE) begin
        host.resp_data <= eng_out;
        host.resp_err  <= 1'b0;
      end
      if (err_accept && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_tpu_op_sequencer.sv
// Scoreboard bench for tpu_op_sequencer with a behavioural engine model.
module tb_tpu_op_sequencer;
  import tpu_seq_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 8;
`ifdef TPU_SEQ_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  typedef enum int {M_OK, M_ERR, M_BOTH, M_SILENT} mode_t;
  typedef struct { mode_t mode; int dly; } job_t;
  typedef struct { logic [15:0] data; logic err; } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        eng_sync, eng_out_hl, eng_ready, eng_error, busy;
  logic [7:0]  eng_in1, eng_in2, err_count;
  logic [15:0] eng_out;

  always #5 clk = ~clk;

  tpu_op_sequencer_if bus();

  tpu_op_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .host       (bus),
    .eng_sync   (eng_sync),
    .eng_out_hl (eng_out_hl),
    .eng_in1    (eng_in1),
    .eng_in2    (eng_in2),
    .eng_ready  (eng_ready),
    .eng_error  (eng_error),
    .eng_out    (eng_out),
    .busy       (busy),
    .err_count  (err_count)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  job_t eng_q[$];
  int   exp_err_acc = 0;
  int   err_base = 0;
  int   exp_hl = 0, exp_sync = 0;
  int   hl_cnt = 0, sync_cnt = 0;
  int   rr_mode = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Consumer side: resp_ready held low, held high, or randomised each cycle.
  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.resp_ready = 1'b0;
        1:       bus.resp_ready = 1'b1;
        default: bus.resp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Response monitor: every accepted response is checked against the queue head.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp: got data 0x%0h err %0b, expected no response", bus.resp_data, bus.resp_err);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_data", 32'(bus.resp_data), 32'(mon_e.data));
          check("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
          if (mon_e.err) exp_err_acc++;
        end
      end
    end
  end

  // Engine model: multiplies its operands and answers after a per-job delay.
  job_t        cur;
  int          cnt;
  bit          pend;
  logic [15:0] prod;
  initial begin
    eng_ready = 1'b0;
    eng_error = 1'b0;
    eng_out   = 16'h0;
    pend      = 1'b0;
    cnt       = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        pend      = 1'b0;
        eng_ready = 1'b0;
        eng_error = 1'b0;
      end else begin
        if (eng_out_hl === 1'b1) hl_cnt++;
        if (eng_sync === 1'b1) begin
          sync_cnt++;
          eng_ready = 1'b0;
          eng_error = 1'b0;
          if (eng_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_sync: got eng_sync=1, expected no job");
            pend = 1'b0;
          end else begin
            cur  = eng_q.pop_front();
            prod = 16'(eng_in1) * 16'(eng_in2);
            cnt  = cur.dly;
            pend = 1'b1;
          end
        end
        if (pend) begin
          if (cnt == 0) begin
            pend = 1'b0;
            case (cur.mode)
              M_OK:    begin eng_ready = 1'b1; eng_out = prod; end
              M_ERR:   eng_error = 1'b1;
              M_BOTH:  begin eng_error = 1'b1; eng_ready = 1'b1; eng_out = prod; end
              default: ;
            endcase
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input mode_t m, input int dly);
    exp_t e;
    job_t j;
    int   k;
    k = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_wait: req_ready stuck at %0b, expected 1", bus.req_ready);
    end else begin
      bus.req_valid = 1'b1;
      bus.req_a     = a;
      bus.req_b     = b;
      j.mode = m;
      j.dly  = dly;
      eng_q.push_back(j);
      e.err  = (m != M_OK);
      e.data = (m == M_OK) ? 16'(a) * 16'(b) : 16'h0000;
      if (m != M_SILENT || TMO_ON) exp_q.push_back(e);
      if (m == M_OK) exp_hl++;
      exp_sync++;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 5000) begin
      n_bad++;
      $display("FAIL drain: got %0d responses outstanding busy=%0b, expected 0 and 0", exp_q.size(), busy);
    end
    @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_err_count"}, 32'(err_count), 32'(sat255(exp_err_acc - err_base)));
    check({tag, "_hl_pulses"}, 32'(hl_cnt), 32'(exp_hl));
    check({tag, "_sync_pulses"}, 32'(sync_cnt), 32'(exp_sync));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_resp_data"}, 32'(bus.resp_data), 32'd0);
    check({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
    check({tag, "_eng_sync"}, 32'(eng_sync), 32'd0);
    check({tag, "_eng_out_hl"}, 32'(eng_out_hl), 32'd0);
    check({tag, "_eng_in1"}, 32'(eng_in1), 32'd0);
    check({tag, "_eng_in2"}, 32'(eng_in2), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int s_at, h_at, r_at;
  initial begin
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Minimum latency: sync at 2, out_HL at 4, resp_valid at 6 cycles after push.
    push(8'h05, 8'h07, M_OK, 0);
    s_at = 0; h_at = 0; r_at = 0;
    for (int k = 1; k <= 40 && r_at == 0; k++) begin
      @(negedge clk);
      if (eng_sync === 1'b1 && s_at == 0)   s_at = k;
      if (eng_out_hl === 1'b1 && h_at == 0) h_at = k;
      if (bus.resp_valid === 1'b1)          r_at = k;
    end
    check("lat_sync", 32'(s_at), 32'd2);
    check("lat_out_hl", 32'(h_at), 32'd4);
    check("lat_resp", 32'(r_at), 32'd6);
    drain();

    push(8'h0D, 8'h0F, M_OK, 3);
    drain();
    checkpoint("single");

    // Backpressure: five jobs with the consumer stalled.
    rr_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) push(8'(8'h11 * (i + 1)), 8'(8'h03 + i), M_OK, 1);
    repeat (3) @(negedge clk);
    check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
    rr_mode = 1;
    drain();
    check("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
    checkpoint("bp");

    // Error and ready together: error wins, no out_HL.
    push(8'h12, 8'h34, M_BOTH, 0);
    drain();
    checkpoint("both");
    check("both_err_count", 32'(err_count), 32'd1);

    // Randomised traffic with a randomly stalling consumer.
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom), 8'($urandom), mode_t'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rr_mode = 1;
    drain();
    checkpoint("rand");

    if (TMO_ON) begin
      push(8'h21, 8'h43, M_SILENT, 0);
      s_at = 0; r_at = 0;
      for (int k = 1; k <= 60 && r_at == 0; k++) begin
        @(negedge clk);
        if (eng_sync === 1'b1 && s_at == 0) s_at = k;
        if (bus.resp_valid === 1'b1)        r_at = k;
      end
      check("tmo_sync", 32'(s_at), 32'd2);
      check("tmo_resp", 32'(r_at), 32'(3 + TMO));
      drain();
      checkpoint("tmo");
    end

    // Reset while waiting on a silent engine with two jobs queued.
    push(8'h55, 8'h66, M_SILENT, 0);
    push(8'h02, 8'h03, M_OK, 0);
    push(8'h04, 8'h05, M_OK, 0);
    if (TMO_ON) begin
      repeat (2) @(negedge clk);
    end else begin
      repeat (100) @(negedge clk);
      check("hang_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("hang_busy", 32'(busy), 32'd1);
    end
    reset = 1'b0;
    exp_q.delete();
    eng_q.delete();
    exp_sync -= 2;
    exp_hl   -= 2;
    err_base = exp_err_acc;
    @(negedge clk);
    check_reset_vals("mid_reset");
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    checkpoint("post_reset");

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) push(8'(i), 8'(i + 1), M_ERR, int'($urandom_range(0, 2)));
    drain();
    checkpoint("sat");
    check("sat_err_count", 32'(err_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tpu_op_sequencer.md
# tpu_op_sequencer

Controller in front of `TPU_functional`: accepts 8-bit operand pairs from an upstream requester, buffers them, and sequences the engine's `sync` / `ready` / `out_HL` handshake one job at a time. It returns each 16-bit result with an error flag on a valid/ready response port. It sits between the host-side command path and the single TPU engine instance, and is the only driver of the engine's control inputs.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 64: WAIT-state watchdog limit; used only with `TPU_SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `req_valid` in 1: operand pair offered.
- `req_ready` out 1: FIFO not full.
- `req_a`, `req_b` in 8 each: operands.
- `resp_valid` out 1: result held.
- `resp_ready` in 1: consumer accepts.
- `resp_data` out 16: engine result; 0 on error.
- `resp_err` out 1: engine `error` seen, or timeout.
- `eng_sync` out 1: engine `sync`.
- `eng_out_hl` out 1: engine `out_HL`.
- `eng_in1`, `eng_in2` out 8 each: engine `input1` / `input2`.
- `eng_ready` in 1, `eng_error` in 1: engine status.
- `eng_out` in 16: engine result.
- `busy` out 1: FSM not in IDLE, or FIFO not empty.
- `err_count` out 8: saturating count of error responses.

## Operation
- **FIFO push:** push on `req_valid && req_ready`. `req_ready = !full`. Push and pop in the same cycle is allowed when non-empty.
- **IDLE:** if FIFO non-empty, pop, latch the operands into the `eng_in1`/`eng_in2` registers, go to ISSUE.
- **ISSUE:** `eng_sync=1` for exactly one cycle, then go to WAIT. `eng_in1`/`eng_in2` stay stable from ISSUE until the FSM returns to IDLE.
- **WAIT:**
  - `eng_error=1` → RESP with `resp_err=1`, `resp_data=0`.
  - Otherwise `eng_ready=1` → READ.
  - `eng_error` has priority when both are high.
  - `eng_ready` is not sampled in ISSUE.
- **READ:** `eng_out_hl=1` for exactly one cycle, then go to CAPTURE.
- **CAPTURE:** `resp_data <= eng_out`, `resp_err <= 0`, then go to RESP.
- **RESP:** `resp_valid=1`, with data and err held stable. On `resp_ready`, go to IDLE. No new job issues while a response is pending. The FIFO still accepts pushes.
- **err_count:** increments by 1 when an error response is accepted; saturates at 255.
- **Reset values:** all outputs 0, except `req_ready=1`. FIFO is empty and the FSM is in IDLE.
- **Reset mid-job:** abandons the job and flushes the FIFO. `eng_sync`/`eng_out_hl` drop to 0 the cycle reset is sampled.

## Timing
- Push at cycle 0 into an empty FIFO with the FSM in IDLE:
  - pop at cycle 1;
  - `eng_sync` high at cycle 2;
  - WAIT from cycle 3;
  - with `eng_ready` high at cycle 3: READ at 4, CAPTURE at 5, `resp_valid` at 6.
- Minimum request-to-response latency is 6 cycles. Back-to-back throughput is one job per 6 cycles plus engine wait plus response stall.
- `req_ready` updates the cycle after the full/empty change, i.e. it is registered from the count.

## Configuration
- **`TPU_SEQ_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no `eng_ready`/`eng_error`, go to RESP with `resp_err=1`, `resp_data=0`, and count it in `err_count`.
- **Undefined:** WAIT is unbounded and there is no counter logic.

## Structure
- **Package `tpu_seq_pkg`:**
  - state enum: IDLE, ISSUE, WAIT, READ, CAPTURE, RESP;
  - `OPERAND_W=8`, `RESULT_W=16`.
- **Sub-module `tpu_seq_fifo`:** synchronous FIFO, width 16 (`{a,b}`), depth `DEPTH`, with full/empty/count outputs.
- **Top level:** FSM and response register.

## Test plan
- **Single job:** push a=0x0D, b=0x0F; engine model raises `eng_ready` 3 cycles after `sync` and drives `eng_out=0x00C3` → one `eng_sync` pulse, one `eng_out_hl` pulse, `resp_data=0x00C3`, `resp_err=0`.
- **Backpressure:** push 5 pairs with `DEPTH=4` and `resp_ready=0` → `req_ready` drops after the FIFO fills. Release `resp_ready` → 5 responses in push order, each with the correct product.
- **Engine error:** `eng_error=1` and `eng_ready=1` in the same WAIT cycle → `resp_err=1`, `resp_data=0`, no `eng_out_hl` pulse, `err_count=1`.
- **Timeout** (macro on, `TIMEOUT_CYCLES=8`): engine never responds → `resp_err=1` exactly 8 WAIT cycles after entering WAIT. With the macro off, the FSM stays in WAIT.
- **Reset mid-WAIT**, with 2 jobs queued → all outputs at reset values next cycle, `busy=0`, no response emitted afterward.
- **Saturation:** 260 error jobs → `err_count` holds at 255.
